uart_rx: RTL and testbench

Serial receive stage for the board UART: it takes the asynchronous RX pad (IOT_50B) and delivers bytes to the machine over a valid/ready handshake. It pairs with the existing transmit path (uart_tx) and runs in the PLL clock domain. The frame format is fixed 8N1, LSB first, sampled at mid-bit from a clock divider. Framing errors and overruns are reported as single-cycle pulses.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_sync2.sv | 24 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and the
// baud divider computation (reused by the transmit side).
package uart_rx_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_t;

    localparam int FRAME_BITS = 8;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs, with a selectable
// reset value so idle-high and idle-low pads both come out of reset quiet.
module uart_rx_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling from a clock divider, one-byte
// holding register with valid/ready handshake, framing and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ = 24_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(FRAME_BITS - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_rx: CLK_HZ/BAUD must be at least 4");
        end
    endgenerate

    logic rxs;

    uart_rx_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift_reg, shift_n;
    logic          byte_done, byte_done_n;
    logic          stop_bad, stop_bad_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_HIGH;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            byte_done <= 1'b0;
            stop_bad  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
            byte_done <= byte_done_n;
            stop_bad  <= stop_bad_n;
        end
    end

    // Every timed state counts down to zero, then acts on the current rxs.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift_reg;
        byte_done_n = 1'b0;
        stop_bad_n  = 1'b0;
        case (state)
            WAIT_HIGH: begin
                if (rxs) state_n = IDLE;
            end
            IDLE: begin
                if (!rxs) begin
                    cnt_n   = HALF_LOAD;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rxs) begin
                        cnt_n     = FULL_LOAD;
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shift_n   = {rxs, shift_reg[7:1]};
                    cnt_n     = FULL_LOAD;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT) state_n = STOP;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        byte_done_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        stop_bad_n = 1'b1;
                        state_n    = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = WAIT_HIGH;
        endcase
    end

    // A completing byte may replace the held one only if it is being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                if (!valid || ready) begin
                    data  <= shift_reg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV = 10: frames are driven bit by bit and
// outputs are observed on the falling edge after each rising edge.
module tb_uart_rx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int         first_valid, first_ferr, first_ovr;
    int         valid_cnt, ferr_cnt, ovr_cnt;
    logic [7:0] first_data, last_data, rst_data;
    logic       last_valid;
    logic [2:0] rst_flags;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, actual, actual, expected, expected);
        end
    endtask

    task automatic clearStats();
        first_valid = -1;
        first_ferr  = -1;
        first_ovr   = -1;
        valid_cnt   = 0;
        ferr_cnt    = 0;
        ovr_cnt     = 0;
        first_data  = 8'h00;
        rst_data    = 8'hFF;
        rst_flags   = 3'b111;
    endtask

    task automatic observe(input int n);
        if (valid) begin
            valid_cnt++;
            if (first_valid < 0) begin
                first_valid = n;
                first_data  = data;
            end
        end
        if (frame_err) begin
            ferr_cnt++;
            if (first_ferr < 0) first_ferr = n;
        end
        if (overrun) begin
            ovr_cnt++;
            if (first_ovr < 0) first_ovr = n;
        end
    endtask

    // Iteration n drives the line for rising edge t0+n, then samples the
    // outputs on the following falling edge.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int tail,
                                 input logic ready_base, input int ready_pulse_at,
                                 input int rst_at);
        clearStats();
        for (int n = 0; n < 100 + tail; n++) begin
            int p;
            p = n / 10;
            if (p == 0)       rx = 1'b0;
            else if (p <= 8)  rx = b[p-1];
            else              rx = stop_bit;
            if (rst_at >= 0 && n >= rst_at) rx = 1'b0;
            ready = (n == ready_pulse_at) ? 1'b1 : ready_base;
            rst   = (n == rst_at);
            @(posedge clk);
            @(negedge clk);
            observe(n);
            if (n == rst_at) begin
                rst_data  = data;
                rst_flags = {valid, frame_err, overrun};
            end
        end
        rst        = 1'b0;
        ready      = ready_base;
        last_data  = data;
        last_valid = valid;
    endtask

    task automatic holdLine(input logic level, input int cycles);
        clearStats();
        rx = level;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            @(negedge clk);
            observe(n);
        end
        last_data  = data;
        last_valid = valid;
    endtask

    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_data", int'(data), 8'h00);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_frame_err", int'(frame_err), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        holdLine(1'b1, 10);

        $display("[TB] plain frame 0xA5");
        applyStimulus(8'hA5, 1'b1, 10, 1'b1, -1, -1);
        checkOutput("a5_valid_time", first_valid, 98);
        checkOutput("a5_valid_cycles", valid_cnt, 1);
        checkOutput("a5_data", int'(first_data), 8'hA5);
        checkOutput("a5_no_ferr", ferr_cnt, 0);
        checkOutput("a5_no_ovr", ovr_cnt, 0);

        $display("[TB] short glitch then frame 0x3C");
        holdLine(1'b0, 3);
        holdLine(1'b1, 20);
        checkOutput("glitch_no_valid", valid_cnt, 0);
        checkOutput("glitch_no_ferr", ferr_cnt, 0);
        applyStimulus(8'h3C, 1'b1, 10, 1'b1, -1, -1);
        checkOutput("3c_valid_time", first_valid, 98);
        checkOutput("3c_data", int'(first_data), 8'h3C);

        $display("[TB] break condition then frame 0x7E");
        applyStimulus(8'h00, 1'b0, 30, 1'b1, -1, -1);
        checkOutput("break_ferr_time", first_ferr, 98);
        checkOutput("break_ferr_cycles", ferr_cnt, 1);
        checkOutput("break_no_valid", valid_cnt, 0);
        holdLine(1'b1, 5);
        applyStimulus(8'h7E, 1'b1, 10, 1'b1, -1, -1);
        checkOutput("7e_valid_time", first_valid, 98);
        checkOutput("7e_data", int'(first_data), 8'h7E);
        checkOutput("7e_no_ferr", ferr_cnt, 0);

        $display("[TB] back-to-back with consumer stalled");
        holdLine(1'b1, 5);
        applyStimulus(8'h12, 1'b1, 0, 1'b0, -1, -1);
        checkOutput("12_valid_time", first_valid, 98);
        applyStimulus(8'h34, 1'b1, 10, 1'b0, -1, -1);
        checkOutput("ovr_valid_held", valid_cnt, 110);
        checkOutput("ovr_cycles", ovr_cnt, 1);
        checkOutput("ovr_time", first_ovr, 98);
        checkOutput("ovr_data_kept", int'(last_data), 8'h12);
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        checkOutput("drain_valid", int'(valid), 0);
        checkOutput("drain_data_kept", int'(data), 8'h12);

        $display("[TB] replace held byte while it is consumed");
        applyStimulus(8'h12, 1'b1, 10, 1'b0, -1, -1);
        checkOutput("hold12_valid", int'(last_valid), 1);
        checkOutput("hold12_data", int'(last_data), 8'h12);
        applyStimulus(8'h34, 1'b1, 10, 1'b0, 98, -1);
        checkOutput("swap_no_ovr", ovr_cnt, 0);
        checkOutput("swap_valid_held", valid_cnt, 110);
        checkOutput("swap_data", int'(last_data), 8'h34);

        $display("[TB] reset mid-frame with line held low");
        applyStimulus(8'hC3, 1'b1, 10, 1'b0, -1, 50);
        checkOutput("midrst_data", int'(rst_data), 8'h00);
        checkOutput("midrst_flags", int'(rst_flags), 0);
        checkOutput("midrst_valid_before", valid_cnt, 50);
        holdLine(1'b0, 70);
        checkOutput("low_no_valid", valid_cnt, 0);
        checkOutput("low_data_zero", int'(last_data), 8'h00);
        holdLine(1'b1, 10);
        applyStimulus(8'h5A, 1'b1, 10, 1'b1, -1, -1);
        checkOutput("5a_valid_time", first_valid, 98);
        checkOutput("5a_data", int'(first_data), 8'h5A);
        checkOutput("5a_no_ferr", ferr_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
